// File: rtl/ram_responder_if.sv
// ---------------------------------------------------------------------------
// ram_responder_if
//   Request/response bundle between the K&S processor (control unit and
//   datapath) and the memory responder.
//
//   Signals:
//     req    requester -> responder  request valid, held until ready
//     we     requester -> responder  1 = write, 0 = read
//     addr   requester -> responder  word address
//     wdata  requester -> responder  write data
//     rdata  responder -> requester  read data, held until the next read
//     ready  responder -> requester  one-cycle completion pulse
//     err    responder -> requester  out-of-range flag, pulses with ready
//     busy   responder -> requester  responder has a transaction in flight
//
//   Modports:
//     master  the processor side that issues requests
//     slave   the memory responder
// ---------------------------------------------------------------------------
interface ram_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              err;
  logic              busy;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ready, err, busy
  );

endinterface

// File: rtl/ram_responder.sv
// ---------------------------------------------------------------------------
// ram_responder
//   Memory-side responder for the K&S processor RAM port. It takes one read
//   or write request at a time, waits LATENCY cycles, performs the access on
//   an internal word array and answers with a single-cycle ready pulse.
//   It stands in for the zero-wait RAM so that multi-cycle memory timing in
//   the control unit can be exercised.
//
//   Parameters:
//     DATA_W   word width in bits
//     ADDR_W   address width in bits
//     DEPTH    implemented words (1 .. 2**ADDR_W); higher addresses flag err
//     LATENCY  cycles from request capture to ready (1 .. 15)
//
//   Ports:
//     clk    single rising-edge clock
//     rst_n  asynchronous active-low reset (memory contents are kept)
//     bus    ram_responder_if.slave: req/we/addr/wdata in,
//            rdata/ready/err/busy out (all outputs registered)
// ---------------------------------------------------------------------------
module ram_responder #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2
) (
  input logic            clk,
  input logic            rst_n,
  ram_responder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // One extra bit so DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0] DEPTH_CMP = (ADDR_W+1)'(DEPTH);
  // WAIT lasts counter+1 cycles, so loading LATENCY-1 puts ready LATENCY
  // cycles after capture.
  localparam logic [3:0]      CNT_LOAD  = 4'(LATENCY - 1);

  state_t            r_state;
  logic [3:0]        r_count;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_ready;
  logic              r_err;
  logic              r_busy;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_inRange;

  assign w_inRange = ({1'b0, r_addr} < DEPTH_CMP);

  assign bus.rdata = r_rdata;
  assign bus.ready = r_ready;
  assign bus.err   = r_err;
  assign bus.busy  = r_busy;

  // Write port of the word array. It has no reset so contents survive
  // rst_n; an asynchronous reset drops the state to IDLE before any edge,
  // which is what keeps an aborted write from being committed.
  always_ff @(posedge clk) begin
    if (r_state == S_RESP && r_we && w_inRange) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  // Transaction FSM. Outputs are produced here as registers so nothing on
  // the bus outputs depends combinationally on the request inputs. Inputs
  // are only looked at in IDLE; WAIT and RESP work purely from the
  // captured copies, so a requester wiggling or dropping req mid-flight
  // cannot disturb or cancel the transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            r_we    <= bus.we;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            r_count <= CNT_LOAD;
            r_busy  <= 1'b1;
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (r_count == 4'd0) begin
            // Read data is fetched on entry to RESP so it is stable for
            // the whole ready cycle; writes leave rdata untouched.
            r_ready <= 1'b1;
            r_err   <= ~w_inRange;
            if (!r_we) begin
              r_rdata <= w_inRange ? r_mem[r_addr] : '0;
            end
            r_state <= S_RESP;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end

        S_RESP: begin
          // A req seen here is deliberately ignored; a held req is picked
          // up again from IDLE on the following edge.
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// ---------------------------------------------------------------------------
// tb_ram_responder
//   Three responders with different DEPTH/LATENCY share one clock:
//     index 0: LATENCY=2,  DEPTH=20
//     index 1: LATENCY=1,  DEPTH=32
//     index 2: LATENCY=15, DEPTH=32
//   Expected results come from a word-array model: ready arrives LATENCY+1
//   cycles after req first rises, addresses >= DEPTH flag err, reads return
//   the stored word (or 0 when out of range), writes leave rdata alone.
// ---------------------------------------------------------------------------
module tb_ram_responder;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;

  int lat[3] = '{2, 1, 15};
  int dep[3] = '{20, 32, 32};

  logic        clk = 1'b0;
  logic        rstN   [3];
  logic        req    [3];
  logic        we     [3];
  logic [4:0]  addr   [3];
  logic [15:0] wdata  [3];
  logic [15:0] rdataS [3];
  logic        rdy    [3];
  logic        errS   [3];
  logic        busyS  [3];

  logic [15:0] refMem [3][32];
  logic [15:0] lastRd [3];

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  ram_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ifc0 ();
  ram_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ifc1 ();
  ram_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ifc2 ();

  assign ifc0.req = req[0]; assign ifc0.we = we[0]; assign ifc0.addr = addr[0]; assign ifc0.wdata = wdata[0];
  assign ifc1.req = req[1]; assign ifc1.we = we[1]; assign ifc1.addr = addr[1]; assign ifc1.wdata = wdata[1];
  assign ifc2.req = req[2]; assign ifc2.we = we[2]; assign ifc2.addr = addr[2]; assign ifc2.wdata = wdata[2];

  assign rdataS[0] = ifc0.rdata; assign rdy[0] = ifc0.ready; assign errS[0] = ifc0.err; assign busyS[0] = ifc0.busy;
  assign rdataS[1] = ifc1.rdata; assign rdy[1] = ifc1.ready; assign errS[1] = ifc1.err; assign busyS[1] = ifc1.busy;
  assign rdataS[2] = ifc2.rdata; assign rdy[2] = ifc2.ready; assign errS[2] = ifc2.err; assign busyS[2] = ifc2.busy;

  ram_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(20), .LATENCY(2)) u0 (
    .clk(clk), .rst_n(rstN[0]), .bus(ifc0.slave));
  ram_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(32), .LATENCY(1)) u1 (
    .clk(clk), .rst_n(rstN[1]), .bus(ifc1.slave));
  ram_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(32), .LATENCY(15)) u2 (
    .clk(clk), .rst_n(rstN[2]), .bus(ifc2.slave));

  // Reference model: predicts err/rdata for one transaction, then commits
  // it to the model array.
  task automatic modelTxn(input int d, input bit w, input logic [4:0] a,
                          input logic [15:0] wd,
                          output logic [15:0] expRd, output logic expErr);
    expErr = (int'(a) >= dep[d]);
    if (w) begin
      expRd = lastRd[d];
      if (!expErr) refMem[d][a] = wd;
    end else begin
      expRd = expErr ? 16'h0000 : refMem[d][a];
      lastRd[d] = expRd;
    end
  endtask

  // Drives one request starting at a rising edge (cycle 0) and observes the
  // following LATENCY+5 cycles at falling edges. Optionally scrambles the
  // request inputs every cycle after capture and drops req early.
  task automatic applyStimulus(input int d, input bit w, input logic [4:0] a,
                               input logic [15:0] wd, input bit scramble,
                               input bit dropEarly,
                               output int rdyCyc, output int rdyCnt,
                               output logic [15:0] rdv, output logic ev,
                               output int busyBad);
    @(posedge clk); #1;
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
    rdyCyc = -1; rdyCnt = 0; busyBad = 0; rdv = 'x; ev = 1'bx;
    for (int c = 0; c <= lat[d] + 4; c++) begin
      @(negedge clk);
      if (rdy[d] === 1'b1) begin
        rdyCnt++;
        if (rdyCyc < 0) begin
          rdyCyc = c; rdv = rdataS[d]; ev = errS[d];
        end
      end
      if (busyS[d] !== ((c >= 1) && (c <= lat[d] + 1))) busyBad++;
      @(posedge clk); #1;
      if (rdyCyc >= 0) begin
        req[d] = 1'b0;
      end else begin
        if (scramble) begin
          we[d] = 1'($urandom); addr[d] = 5'($urandom); wdata[d] = 16'($urandom);
        end
        if (dropEarly) req[d] = 1'b0;
      end
    end
    req[d] = 1'b0;
  endtask

  task automatic test_reset();
    int pulses;
    for (int d = 0; d < 3; d++) begin
      rstN[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
      lastRd[d] = 16'h0000;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      nChecks++; if (rdataS[d] !== 16'h0000) begin nErrors++; $display("FAIL reset_rdata[%0d]: got %h expected 0000", d, rdataS[d]); end
      nChecks++; if (rdy[d] !== 1'b0) begin nErrors++; $display("FAIL reset_ready[%0d]: got %b expected 0", d, rdy[d]); end
      nChecks++; if (errS[d] !== 1'b0) begin nErrors++; $display("FAIL reset_err[%0d]: got %b expected 0", d, errS[d]); end
      nChecks++; if (busyS[d] !== 1'b0) begin nErrors++; $display("FAIL reset_busy[%0d]: got %b expected 0", d, busyS[d]); end
    end
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) rstN[d] = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) if (rdy[d] !== 1'b0 || busyS[d] !== 1'b0) pulses++;
    end
    nChecks++; if (pulses != 0) begin nErrors++; $display("FAIL idle_quiet: got %0d ready/busy samples expected 0", pulses); end
  endtask

  task automatic test_write_read();
    int cyc, cnt, bb; logic [15:0] rv, er; logic ev, ee;
    modelTxn(0, 1'b1, 5'd5, 16'hBEEF, er, ee);
    applyStimulus(0, 1'b1, 5'd5, 16'hBEEF, 1'b0, 1'b0, cyc, cnt, rv, ev, bb);
    nChecks++; if (cyc != 3 || cnt != 1) begin nErrors++; $display("FAIL wr_timing: got cycle %0d count %0d expected cycle 3 count 1", cyc, cnt); end
    nChecks++; if (bb != 0) begin nErrors++; $display("FAIL wr_busy: got %0d bad cycles expected 0", bb); end
    nChecks++; if (ev !== ee) begin nErrors++; $display("FAIL wr_err: got %b expected %b", ev, ee); end
    modelTxn(0, 1'b0, 5'd5, 16'h0000, er, ee);
    applyStimulus(0, 1'b0, 5'd5, 16'h0000, 1'b0, 1'b0, cyc, cnt, rv, ev, bb);
    nChecks++; if (cyc != 3 || cnt != 1) begin nErrors++; $display("FAIL rd_timing: got cycle %0d count %0d expected cycle 3 count 1", cyc, cnt); end
    nChecks++; if (rv !== er) begin nErrors++; $display("FAIL rd_data: got %h expected %h", rv, er); end
    repeat (5) @(negedge clk);
    nChecks++; if (rdataS[0] !== er) begin nErrors++; $display("FAIL rd_hold: got %h expected %h", rdataS[0], er); end
  endtask

  task automatic test_latency();
    int cyc, cnt, bb; logic [15:0] rv, er, v; logic ev, ee; logic [4:0] a;
    for (int d = 1; d < 3; d++) begin
      a = 5'($urandom); v = 16'($urandom);
      modelTxn(d, 1'b1, a, v, er, ee);
      applyStimulus(d, 1'b1, a, v, 1'b0, 1'b0, cyc, cnt, rv, ev, bb);
      nChecks++; if (cyc != lat[d] + 1 || cnt != 1) begin nErrors++; $display("FAIL lat_wr[%0d]: got cycle %0d count %0d expected cycle %0d count 1", d, cyc, cnt, lat[d] + 1); end
      modelTxn(d, 1'b0, a, 16'h0000, er, ee);
      applyStimulus(d, 1'b0, a, 16'h0000, 1'b0, 1'b0, cyc, cnt, rv, ev, bb);
      nChecks++; if (cyc != lat[d] + 1 || cnt != 1) begin nErrors++; $display("FAIL lat_rd[%0d]: got cycle %0d count %0d expected cycle %0d count 1", d, cyc, cnt, lat[d] + 1); end
      nChecks++; if (rv !== er) begin nErrors++; $display("FAIL lat_data[%0d]: got %h expected %h", d, rv, er); end
      nChecks++; if (bb != 0) begin nErrors++; $display("FAIL lat_busy[%0d]: got %0d bad cycles expected 0", d, bb); end
    end
  endtask

  task automatic test_out_of_range();
    int cyc, cnt, bb; logic [15:0] rv, er; logic ev, ee;
    modelTxn(0, 1'b0, 5'd25, 16'h0000, er, ee);
    applyStimulus(0, 1'b0, 5'd25, 16'h0000, 1'b0, 1'b0, cyc, cnt, rv, ev, bb);
    nChecks++; if (ev !== ee || rv !== er || cnt != 1) begin nErrors++; $display("FAIL oor_read: got err %b data %h count %0d expected err %b data %h count 1", ev, rv, cnt, ee, er); end
    modelTxn(0, 1'b1, 5'd25, 16'h1234, er, ee);
    applyStimulus(0, 1'b1, 5'd25, 16'h1234, 1'b0, 1'b0, cyc, cnt, rv, ev, bb);
    nChecks++; if (ev !== ee || rv !== er) begin nErrors++; $display("FAIL oor_write: got err %b data %h expected err %b data %h", ev, rv, ee, er); end
    modelTxn(0, 1'b0, 5'd5, 16'h0000, er, ee);
    applyStimulus(0, 1'b0, 5'd5, 16'h0000, 1'b0, 1'b0, cyc, cnt, rv, ev, bb);
    nChecks++; if (ev !== ee || rv !== er) begin nErrors++; $display("FAIL oor_intact: got err %b data %h expected err %b data %h", ev, rv, ee, er); end
  endtask

  task automatic test_busy_inputs();
    int cyc, cnt, bb; logic [15:0] rv, er, v; logic ev, ee;
    v = 16'($urandom);
    modelTxn(0, 1'b1, 5'd9, v, er, ee);
    applyStimulus(0, 1'b1, 5'd9, v, 1'b1, 1'b1, cyc, cnt, rv, ev, bb);
    nChecks++; if (cyc != 3 || cnt != 1 || ev !== ee) begin nErrors++; $display("FAIL scramble_txn: got cycle %0d count %0d err %b expected cycle 3 count 1 err %b", cyc, cnt, ev, ee); end
    nChecks++; if (bb != 0) begin nErrors++; $display("FAIL scramble_busy: got %0d bad cycles expected 0", bb); end
    modelTxn(0, 1'b0, 5'd9, 16'h0000, er, ee);
    applyStimulus(0, 1'b0, 5'd9, 16'h0000, 1'b0, 1'b0, cyc, cnt, rv, ev, bb);
    nChecks++; if (rv !== er) begin nErrors++; $display("FAIL scramble_commit: got %h expected %h", rv, er); end
  endtask

  task automatic test_back_to_back();
    int r1, r2, cnt; logic [15:0] v, rv;
    v = 16'($urandom);
    r1 = -1; r2 = -1; cnt = 0; rv = 'x;
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 5'd3; wdata[0] = v;
    for (int c = 0; c <= 2 * (lat[0] + 2) + 3; c++) begin
      @(negedge clk);
      if (rdy[0] === 1'b1) begin
        cnt++;
        if (r1 < 0) r1 = c;
        else if (r2 < 0) begin r2 = c; rv = rdataS[0]; end
      end
      @(posedge clk); #1;
      if (r2 >= 0) req[0] = 1'b0;
      else if (r1 >= 0) we[0] = 1'b0;
    end
    req[0] = 1'b0;
    refMem[0][3] = v; lastRd[0] = v;
    nChecks++; if (r1 != lat[0] + 1 || r2 != 2 * lat[0] + 3 || cnt != 2) begin nErrors++; $display("FAIL b2b_timing: got %0d/%0d count %0d expected %0d/%0d count 2", r1, r2, cnt, lat[0] + 1, 2 * lat[0] + 3); end
    nChecks++; if (rv !== v) begin nErrors++; $display("FAIL b2b_data: got %h expected %h", rv, v); end
  endtask

  task automatic test_reset_mid();
    int cyc, cnt, bb, pulses; logic [15:0] rv, er; logic ev, ee;
    modelTxn(0, 1'b1, 5'd7, 16'h0011, er, ee);
    applyStimulus(0, 1'b1, 5'd7, 16'h0011, 1'b0, 1'b0, cyc, cnt, rv, ev, bb);
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 5'd7; wdata[0] = 16'hDEAD;
    @(posedge clk); #2;
    rstN[0] = 1'b0;
    #1;
    nChecks++; if (busyS[0] !== 1'b0) begin nErrors++; $display("FAIL rstmid_busy: got %b expected 0", busyS[0]); end
    req[0] = 1'b0;
    lastRd[0] = 16'h0000;
    pulses = 0;
    repeat (2) begin @(negedge clk); if (rdy[0] !== 1'b0) pulses++; end
    @(posedge clk); #1;
    rstN[0] = 1'b1;
    for (int c = 0; c < lat[0] + 4; c++) begin @(negedge clk); if (rdy[0] !== 1'b0 || busyS[0] !== 1'b0) pulses++; end
    nChecks++; if (pulses != 0) begin nErrors++; $display("FAIL rstmid_quiet: got %0d ready/busy samples expected 0", pulses); end
    nChecks++; if (rdataS[0] !== 16'h0000) begin nErrors++; $display("FAIL rstmid_rdata: got %h expected 0000", rdataS[0]); end
    modelTxn(0, 1'b0, 5'd7, 16'h0000, er, ee);
    applyStimulus(0, 1'b0, 5'd7, 16'h0000, 1'b0, 1'b0, cyc, cnt, rv, ev, bb);
    nChecks++; if (rv !== er) begin nErrors++; $display("FAIL rstmid_nocommit: got %h expected %h", rv, er); end
  endtask

  task automatic test_random();
    int cyc, cnt, bb; logic [15:0] rv, er, v; logic ev, ee, w; logic [4:0] a;
    for (int i = 0; i < dep[0]; i++) begin
      v = 16'($urandom);
      modelTxn(0, 1'b1, 5'(i), v, er, ee);
      applyStimulus(0, 1'b1, 5'(i), v, 1'b0, 1'b0, cyc, cnt, rv, ev, bb);
      nChecks++; if (cyc != 3 || cnt != 1 || ev !== ee) begin nErrors++; $display("FAIL fill[%0d]: got cycle %0d count %0d err %b", i, cyc, cnt, ev); end
    end
    for (int i = 0; i < 30; i++) begin
      w = 1'($urandom); a = 5'($urandom); v = 16'($urandom);
      modelTxn(0, w, a, v, er, ee);
      applyStimulus(0, w, a, v, 1'b0, 1'b0, cyc, cnt, rv, ev, bb);
      nChecks++; if (cyc != 3 || cnt != 1 || bb != 0) begin nErrors++; $display("FAIL rand_timing[%0d]: got cycle %0d count %0d busybad %0d expected 3 1 0", i, cyc, cnt, bb); end
      nChecks++; if (ev !== ee) begin nErrors++; $display("FAIL rand_err[%0d]: got %b expected %b (we=%b addr=%0d)", i, ev, ee, w, a); end
      nChecks++; if (rv !== er) begin nErrors++; $display("FAIL rand_data[%0d]: got %h expected %h (we=%b addr=%0d)", i, rv, er, w, a); end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] ram_responder bench start");
    test_reset();
    test_write_read();
    test_latency();
    test_out_of_range();
    test_busy_inputs();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Memory-side responder for the K&S processor's data/instruction RAM port.
- The control unit and datapath issue the memory requests; this block answers them.
- It accepts one read or write request at a time, waits a programmable number of cycles, performs the access on an internal word array, then returns data and a one-cycle ready pulse.
- It replaces the zero-wait RAM so multi-cycle memory timing can be exercised.

Parameters:
- DATA_W, 16, word width in bits
- ADDR_W, 5, address width in bits
- DEPTH, 32, number of implemented words; must be 1..2**ADDR_W
- LATENCY, 2, cycles from request capture to ready; must be 1..15

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  1  request valid; held high by the requester until ready
- we  in  1  1 = write, 0 = read; sampled with req
- addr  in  ADDR_W  word address; sampled with req
- wdata  in  DATA_W  write data; sampled with req
- rdata  out  DATA_W  read data; valid in the ready cycle, held until the next read completes
- ready  out  1  one-cycle completion pulse
- err  out  1  pulses with ready when the captured addr >= DEPTH
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, counter=0, rdata=0, ready=0, err=0, busy=0, captured registers=0.
  - The memory array has no reset; its contents are preserved across rst_n.
  - Reset during WAIT/RESP aborts the transaction. A pending write is not committed.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If req=1 at a rising edge: capture we/addr/wdata, load counter=LATENCY-1, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If counter==0, go to RESP; otherwise decrement counter.
  - req, we, addr and wdata are ignored; only captured values are used.
- RESP: ready=1 for exactly this cycle, then go to IDLE.
  - Read, in range: rdata = mem[captured addr], registered on entry to RESP so it is valid throughout the cycle. err=0.
  - Write, in range: mem[captured addr] written at the edge that leaves RESP. rdata unchanged. err=0.
  - Out of range (addr >= DEPTH): err=1. A write is discarded; a read forces rdata=0.
- Timing: with req first high in cycle 0, ready is high in cycle LATENCY+1 (LATENCY=1 gives ready in cycle 2).
- Throughput: req still high in the cycle after RESP (IDLE) starts a new transaction. Back-to-back spacing is LATENCY+2 cycles.
- req sampled high during RESP is ignored, so no overlapping transaction is started.
- Read-after-write: a read issued after a write's ready returns the written data.
- Dropping req early (during WAIT) does not cancel the transaction; it still completes.
- busy=1 throughout WAIT and RESP.
- ready, err and rdata are registered outputs with no combinational path from inputs.

Test Plan:
- Reset then idle: rst_n low 3 cycles, no req → rdata=0, ready=0, err=0, busy=0; no ready pulse for 20 cycles.
- Write then read, LATENCY=2: write addr=5, wdata=16'hBEEF, req cycle 0 → ready only in cycle 3, busy cycles 1-3. Then read addr=5 → ready after 3 cycles with rdata=16'hBEEF; rdata still 16'hBEEF 5 cycles later.
- Latency sweep: LATENCY=1 and LATENCY=15 → ready exactly 2 and 16 cycles after req first high. Exactly one ready pulse per request.
- Out of range, DEPTH=20: read addr=25 → ready=1, err=1, rdata=0. Write addr=25, 16'h1234, then read addr=(25 mod 32 aliasing irrelevant) addr=5 → addr 5 data unchanged, err=1 on the write.
- Input changes while busy: change addr/wdata/we every WAIT cycle and drop req mid-WAIT → captured values used, single completion, original write committed.
- Reset mid-write: rst_n pulsed low during WAIT of a write to addr=7 (prior value 16'h0011) → ready never pulses, busy=0 immediately; a later read of addr=7 returns 16'h0011.
